score_draw_ctrl: RTL and testbench
==================================

// Module: score_draw_ctrl
// PURPOSE
//  Sequences drawing of a multi-digit BCD score onto the 160x120 VGA framebuffer.
//  Walks every glyph pixel of every digit and drives the score glyph ROM
//  (3-bit colour, 1-cycle read latency). Emits one x/y/colour/plot pixel per clock
//  to the VGA adapter. Sits between game logic (start/score) and the VGA plot port.
// PARAMETERS
//  NUM_DIGITS  4     digits drawn, most significant at lowest x
//  GLYPH_W     16    glyph width in pixels (power of 2; col counter log2 wide)
//  GLYPH_H     16    glyph height in pixels (power of 2; row counter log2 wide)
//  BG_COLOUR   3'b000 colour written for blanked leading-zero digits
//  BLANK_LZ    1     1 = leading zeros drawn as BG_COLOUR; 0 = drawn as glyph "0"
// PORTS
//  clock      in   1     system clock
//  reset      in   1     asynchronous, active-high reset
//  start      in   1     request redraw; sampled only in IDLE
//  score_bcd  in   4*NUM_DIGITS  BCD digits, [3:0] = least significant digit
//  base_x     in   8     top-left x of the score field
//  base_y     in   7     top-left y of the score field
//  rom_addr   out  12    glyph ROM address {digit[3:0], row[3:0], col[3:0]}
//  rom_q      in   3     glyph ROM data, valid one cycle after rom_addr
//  x          out  8     pixel x to VGA adapter
//  y          out  7     pixel y to VGA adapter
//  colour     out  3     pixel colour to VGA adapter
//  plot       out  1     write-enable to VGA adapter, one pixel per high cycle
//  busy       out  1     high while a draw is in progress
//  done       out  1     single-cycle pulse when a draw completes
// BEHAVIOUR
//  - Reset (async): state IDLE; counters, x, y, colour, plot, busy, done all 0.
//    Reset mid-draw aborts immediately; no further plot until the next start.
//  - States: IDLE -> DRAW -> FLUSH -> DONE -> IDLE.
//    IDLE: start=1 at edge E latches score_bcd, base_x, base_y; clears digit/row/col;
//          -> DRAW. busy=1 from the cycle after E. start is ignored outside IDLE.
//    DRAW: one address per cycle; col is innermost, then row, then digit (digit 0 = MSD).
//          Leaves for FLUSH after the address of the last pixel
//          (digit=NUM_DIGITS-1, row=GLYPH_H-1, col=GLYPH_W-1).
//    FLUSH: one cycle; the last pixel is plotted. -> DONE.
//    DONE: done=1, busy=0, plot=0 for exactly one cycle. -> IDLE.
//    A start asserted during DONE is ignored; start is first honoured in IDLE.
//  - rom_addr is combinational from the latched digit value and the row/col counters.
//    A pipeline register delays x/y/valid/blank by 1 cycle to align with rom_q.
//  - Pixel output (cycle after its address):
//    x = base_x + digit_idx*GLYPH_W + col, computed 8-bit; the carry is kept for
//        the bound check. y = base_y + row, computed 7-bit; the carry is kept.
//    plot = valid AND x<160 AND y<120, with no wrap. Off-screen pixels are
//    consumed but not plotted.
//    colour = BG_COLOUR if blank, else rom_q. Transparency is not supported;
//    every on-screen pixel is written.
//  - Leading-zero blanking (BLANK_LZ=1): digit k is blank iff it and all more
//    significant digits are 0. The least significant digit is never blank.
//  - Latency: start edge E -> first plot in cycle E+2. Total plot cycles =
//    NUM_DIGITS*GLYPH_W*GLYPH_H (1024 at defaults) when fully on screen.
//    done pulses in the cycle after the last plot.
//  - Outputs x/y/colour hold their last values when plot=0. Invalid BCD (>9) is
//    passed to the ROM unchanged.
// TESTING
//  1. Reset then start with score=0x1234, base=(8,4): exactly 1024 plot cycles;
//     first pixel x=8,y=4, addr 0x100; last pixel x=71,y=19; a single done pulse
//     follows the last plot.
//  2. score=0x0007, BLANK_LZ=1: pixels with x<56 have colour BG_COLOUR; digit 3
//     addresses {7,row,col}; score=0x0000 -> only digit 3 drawn as glyph 0.
//  3. ROM model returns addr[2:0]: colour at each plot equals the low bits of the
//     previous cycle's rom_addr (checks 1-cycle alignment).
//  4. base_x=150: only pixels with x<160 plot (10 per row); done still arrives
//     after 1025 draw cycles.
//  5. Start pulsed during DRAW and during DONE: no restart, exactly one done;
//     start held high in IDLE -> back-to-back draws.
//  6. Assert reset at pixel 300: plot, busy and done go 0 asynchronously; a new
//     start afterwards gives a full 1024-pixel draw.

Source files
------------

// File: rtl/score_draw_ctrl.sv
// Score field sequencer: walks every glyph pixel of each BCD digit,
// drives the glyph ROM and plots the aligned pixel to the VGA adapter.
module score_draw_ctrl #(
  parameter int       NUM_DIGITS = 4,
  parameter int       GLYPH_W    = 16,
  parameter int       GLYPH_H    = 16,
  parameter bit [2:0] BG_COLOUR  = 3'b000,
  parameter bit       BLANK_LZ   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] score_bcd,
  input  logic [7:0]              base_x,
  input  logic [6:0]              base_y,
  output logic [11:0]             rom_addr,
  input  logic [2:0]              rom_q,
  output logic [7:0]              x,
  output logic [6:0]              y,
  output logic [2:0]              colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(GLYPH_W);
  localparam int RW = $clog2(GLYPH_H);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FLUSH,
    DONE
  } state_t;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] score_q;
  logic [7:0]              bx;
  logic [6:0]              by;
  logic [DW-1:0]           dig;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic                    blank_q;
  logic [2:0]              col_hold;

  logic [3:0] dval;
  logic [3:0] kd;
  logic       cur_blank;
  logic       run;
  logic [8:0] xs;
  logic [7:0] ys;
  logic       onscr;
  logic       last;

  // run stays set while every digit so far (from the MSD) is zero
  always_comb begin
    dval      = '0;
    kd        = '0;
    cur_blank = 1'b0;
    run       = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      kd  = score_q[4*(NUM_DIGITS-1-k) +: 4];
      run = run && (kd == 4'd0);
      if (dig == DW'(k)) begin
        dval      = kd;
        cur_blank = BLANK_LZ && run && (k != NUM_DIGITS-1);
      end
    end
  end

  assign rom_addr = 12'({dval, row, col});

  assign xs    = {1'b0, bx} + (9'(dig) << CW) + 9'(col);
  assign ys    = {1'b0, by} + 8'(row);
  assign onscr = (xs < 9'd160) && (ys < 8'd120);
  assign last  = (dig == DW'(NUM_DIGITS-1)) && (&row) && (&col);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      score_q <= '0;
      bx      <= '0;
      by      <= '0;
      dig     <= '0;
      row     <= '0;
      col     <= '0;
      blank_q <= 1'b0;
      x       <= '0;
      y       <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            score_q <= score_bcd;
            bx      <= base_x;
            by      <= base_y;
            dig     <= '0;
            row     <= '0;
            col     <= '0;
            busy    <= 1'b1;
            state   <= DRAW;
          end
        end
        DRAW: begin
          // off-screen pixels advance the walk but leave x/y untouched
          plot <= onscr;
          if (onscr) begin
            x       <= xs[7:0];
            y       <= ys[6:0];
            blank_q <= cur_blank;
          end
          col <= col + 1'b1;
          if (&col) begin
            row <= row + 1'b1;
            if (&row) dig <= dig + 1'b1;
          end
          if (last) state <= FLUSH;
        end
        FLUSH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    colour = col_hold;
    if (plot) colour = blank_q ? BG_COLOUR : rom_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     col_hold <= '0;
    else if (plot) col_hold <= colour;
  end

endmodule

// File: tb/tb_score_draw_ctrl.sv
// Scoreboard bench for score_draw_ctrl: expected pixels queued at start,
// popped and compared on every plot cycle.
module tb_score_draw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] score;
  logic [7:0]  bx;
  logic [6:0]  by;
  logic [11:0] rom_addr;
  logic [2:0]  rom_q;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int nplot = 0;
  logic [11:0] prev_addr = '0;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic [11:0] a;
  } pix_t;

  pix_t q[$];

  always #5 clk = ~clk;

  score_draw_ctrl dut (
    .clock     (clk),
    .reset     (rst),
    .start     (start),
    .score_bcd (score),
    .base_x    (bx),
    .base_y    (by),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  // glyph ROM stand-in: returns the low address bits one cycle later
  always @(posedge clk) rom_q <= rom_addr[2:0];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] sc, input int px, input int py);
    logic [3:0] dv;
    bit         zr;
    bit         bl;
    int         xs;
    int         ys;
    pix_t       p;
    zr = 1'b1;
    for (int d = 0; d < 4; d++) begin
      dv = sc[4*(3-d) +: 4];
      zr = zr && (dv == 4'd0);
      bl = zr && (d != 3);
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          xs = px + d*16 + c;
          ys = py + r;
          if (xs < 160 && ys < 120) begin
            p.x = xs[7:0];
            p.y = ys[6:0];
            p.c = bl ? 3'b000 : c[2:0];
            p.a = {dv, r[3:0], c[3:0]};
            q.push_back(p);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (plot) begin
      nplot++;
      if (q.size() == 0) begin
        check("extra_plot", 1, 0);
      end else begin
        e = q.pop_front();
        check("x", int'(x), int'(e.x));
        check("y", int'(y), int'(e.y));
        check("colour", int'(colour), int'(e.c));
        check("addr", int'(prev_addr), int'(e.a));
      end
    end
    prev_addr = rom_addr;
  end

  task automatic run(input logic [15:0] sc, input int px, input int py,
                     input int expn, input bit poke);
    int n;
    bit got;
    push(sc, px, py);
    @(negedge clk);
    score = sc;
    bx    = px[7:0];
    by    = py[6:0];
    start = 1'b1;
    nplot = 0;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    got   = 1'b0;
    check("busy_rise", int'(busy), 1);
    while (n < 3000 && !got) begin
      if (poke && n == 100) start = 1'b1;
      if (poke && n == 101) start = 1'b0;
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    check("done_latency", n, 1026);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_width", int'(done), 0);
    check("busy_fall", int'(busy), 0);
    repeat (4) begin
      @(negedge clk);
      check("stay_idle", int'(busy), 0);
    end
    check("plot_count", nplot, expn);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    score = '0;
    bx    = '0;
    by    = '0;
    repeat (3) @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    rst = 1'b0;

    run(16'h1234, 8, 4, 1024, 1'b0);
    run(16'h0007, 8, 4, 1024, 1'b0);
    run(16'h0000, 20, 30, 1024, 1'b0);
    run(16'h0901, 0, 110, 640, 1'b0);
    run(16'h5678, 150, 0, 160, 1'b0);
    run(16'h1234, 8, 4, 1024, 1'b1);

    // start held high: second draw begins straight out of IDLE
    push(16'h4321, 40, 50);
    push(16'h4321, 40, 50);
    @(negedge clk);
    score = 16'h4321;
    bx    = 8'd40;
    by    = 7'd50;
    start = 1'b1;
    nplot = 0;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check("b2b_done1", n, 1026);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n     = 1028;
    check("b2b_busy", int'(busy), 1);
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 5000);
    check("b2b_done2", n, 2053);
    repeat (3) @(negedge clk);
    check("b2b_plots", nplot, 2048);
    check("b2b_queue", q.size(), 0);

    // asynchronous abort mid-draw
    push(16'h1234, 8, 4);
    @(negedge clk);
    score = 16'h1234;
    bx    = 8'd8;
    by    = 7'd4;
    start = 1'b1;
    nplot = 0;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (nplot < 300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", nplot, 300);
    rst = 1'b1;
    #1;
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle", int'(busy), 0);
    run(16'h1234, 8, 4, 1024, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
